// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide issue controller.
package multdiv_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Operation select carried on req_op
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Default timing parameters
  localparam int unsigned DEF_MAX_CYC    = 40;
  localparam int unsigned DEF_IGNORE_CYC = 2;

  // Datapath widths
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RD_W   = 5;

endpackage

// File: rtl/multdiv_wait_ctr.sv
// Saturating WAIT-phase cycle counter with RDY qualification and timeout flag.
module multdiv_wait_ctr
  import multdiv_pkg::*;
#(
  parameter int unsigned MAX_CYC    = DEF_MAX_CYC,
  parameter int unsigned IGNORE_CYC = DEF_IGNORE_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  input  logic rdy,
  output logic qual_c,
  output logic last_c
);

  localparam int unsigned CNT_W = $clog2(MAX_CYC + 1);

  logic [CNT_W-1:0] cnt;

  // Clear on load, count while enabled, stick at MAX_CYC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_W'(MAX_CYC))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // RDY seen in the first IGNORE_CYC cycles may be left over from the previous op
  assign qual_c = rdy & (cnt >= CNT_W'(IGNORE_CYC));
  assign last_c = (cnt == CNT_W'(MAX_CYC - 1));

endmodule

// File: rtl/mydffe.sv
// Single-bit enabled flop with asynchronous active-high clear.
module mydffe (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  // Hold unless enabled; clear on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg32.sv
// 32-bit enabled register built from mydffe cells.
module reg32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  for (genvar i = 0; i < 32; i++) begin : g_bit
    mydffe u_bit (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .d   (d[i]),
      .q   (q[i])
    );
  end

endmodule

// File: rtl/multdiv_issue.sv
// Pipeline-side initiator for the multiplier/divider ctrl protocol.
module multdiv_issue
  import multdiv_pkg::*;
#(
  parameter int unsigned MAX_CYC    = DEF_MAX_CYC,
  parameter int unsigned IGNORE_CYC = DEF_IGNORE_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [RD_W-1:0]   req_rd,
  input  logic              flush,
  output logic              req_ready,
  output logic              stall,
  output logic              ctrl_MULT,
  output logic              ctrl_DIV,
  output logic [DATA_W-1:0] data_operandA,
  output logic [DATA_W-1:0] data_operandB,
  input  logic [DATA_W-1:0] data_result,
  input  logic              data_exception,
  input  logic              data_resultRDY,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_exception,
  output logic              wb_timeout
);

  state_e            state_q;
  state_e            state_d;
  logic              accept_c;
  logic              load_c;
  logic              cap_c;
  logic              cap_timeout_c;
  logic              qual_c;
  logic              last_c;
  logic              op_q;
  logic [RD_W-1:0]   rd_q;
  logic [DATA_W-1:0] wb_data_d;

  // flush in IDLE blocks acceptance of a same-cycle request
  assign accept_c = (state_q == ST_IDLE) & req_valid & ~flush;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, counter load and result capture strobes
  always_comb begin
    state_d       = state_q;
    load_c        = 1'b0;
    cap_c         = 1'b0;
    cap_timeout_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        load_c  = 1'b1;
        state_d = flush ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (qual_c) begin
          cap_c   = 1'b1;
          state_d = ST_DONE;
        end else if (last_c) begin
          cap_c         = 1'b1;
          cap_timeout_c = 1'b1;
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered handshake, ctrl pulses and writeback strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b1;
      stall     <= 1'b0;
      ctrl_MULT <= 1'b0;
      ctrl_DIV  <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
    end else begin
      req_ready <= (state_d == ST_IDLE);
      stall     <= (state_d != ST_IDLE);
      ctrl_MULT <= accept_c & (req_op == OP_MULT);
      ctrl_DIV  <= accept_c & (req_op == OP_DIV);
      wb_valid  <= (state_d == ST_DONE);
      if (state_d == ST_DONE) begin
        wb_rd <= rd_q;
      end
    end
  end

  multdiv_wait_ctr #(
    .MAX_CYC    (MAX_CYC),
    .IGNORE_CYC (IGNORE_CYC)
  ) u_wait_ctr (
    .clk    (clk),
    .rst    (rst),
    .load   (load_c),
    .en     (state_q == ST_WAIT),
    .rdy    (data_resultRDY),
    .qual_c (qual_c),
    .last_c (last_c)
  );

  // Request latches: operands drive the unit directly
  reg32 u_opa (
    .clk (clk),
    .rst (rst),
    .en  (accept_c),
    .d   (req_a),
    .q   (data_operandA)
  );

  reg32 u_opb (
    .clk (clk),
    .rst (rst),
    .en  (accept_c),
    .d   (req_b),
    .q   (data_operandB)
  );

  mydffe u_op (
    .clk (clk),
    .rst (rst),
    .en  (accept_c),
    .d   (req_op),
    .q   (op_q)
  );

  for (genvar i = 0; i < int'(RD_W); i++) begin : g_rd
    mydffe u_rd (
      .clk (clk),
      .rst (rst),
      .en  (accept_c),
      .d   (req_rd[i]),
      .q   (rd_q[i])
    );
  end

  // Result latches: hold until the next capture; a timeout reports zero data
  assign wb_data_d = cap_timeout_c ? '0 : data_result;

  reg32 u_wb_data (
    .clk (clk),
    .rst (rst),
    .en  (cap_c),
    .d   (wb_data_d),
    .q   (wb_data)
  );

  mydffe u_wb_exc (
    .clk (clk),
    .rst (rst),
    .en  (cap_c),
    .d   (cap_timeout_c | data_exception),
    .q   (wb_exception)
  );

  mydffe u_wb_to (
    .clk (clk),
    .rst (rst),
    .en  (cap_c),
    .d   (cap_timeout_c),
    .q   (wb_timeout)
  );

  // The latched op only selects the ctrl pulse, which is decided at acceptance
  logic unused_op;
  assign unused_op = op_q;

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed scoreboard bench for multdiv_issue.
module tb_multdiv_issue;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_rd;
  logic        flush;
  logic        req_ready;
  logic        stall;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;
  logic        wb_timeout;

  multdiv_issue dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_op         (req_op),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_rd         (req_rd),
    .flush          (flush),
    .req_ready      (req_ready),
    .stall          (stall),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .wb_exception   (wb_exception),
    .wb_timeout     (wb_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected writeback: op cycle it appears in (acceptance edge = cycle 0) and payload
  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
    logic        to;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int passed = 0;
  int cyc    = 0;
  int t0     = 0;
  int n_mult = 0;
  int n_div  = 0;
  int n_both = 0;
  int n_stall = 0;

  // Unit model: raise RDY at op cycle rdy_on with m_res/m_exc, drop it at rdy_off
  int          rdy_on  = -1;
  int          rdy_off = -1;
  logic [31:0] m_res   = '0;
  logic        m_exc   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(input int c, input logic [4:0] rd, input logic [31:0] d,
                      input logic exc, input logic to);
    exp_t e;
    e.cyc = c; e.rd = rd; e.data = d; e.exc = exc; e.to = to;
    sb.push_back(e);
  endtask

  // One cycle: sample at negedge, score writebacks, then drive the unit model
  task automatic step();
    exp_t e;
    int   opc;
    @(negedge clk);
    cyc++;
    if (ctrl_MULT) n_mult++;
    if (ctrl_DIV) n_div++;
    if (ctrl_MULT && ctrl_DIV) n_both++;
    if (stall) n_stall++;
    if (wb_valid) begin
      if (sb.size() == 0) begin
        chk("wb_spurious", 32'(wb_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_cycle", 32'(cyc - t0), 32'(e.cyc));
        chk("wb_rd", 32'(wb_rd), 32'(e.rd));
        chk("wb_data", wb_data, e.data);
        chk("wb_exception", 32'(wb_exception), 32'(e.exc));
        chk("wb_timeout", 32'(wb_timeout), 32'(e.to));
      end
    end
    opc = cyc - t0;
    if (opc == rdy_on) begin
      data_resultRDY = 1'b1;
      data_result    = m_res;
      data_exception = m_exc;
    end
    if (opc == rdy_off) data_resultRDY = 1'b0;
  endtask

  // Present one request for one edge; afterwards the bench sits in op cycle 1
  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    t0 = cyc;
    n_mult = 0; n_div = 0; n_stall = 0;
    step();
    req_valid = 1'b0; req_a = '0; req_b = '0; req_rd = '0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0; req_rd = '0;
    flush = 1'b0;
    data_result = '0; data_exception = 1'b0; data_resultRDY = 1'b0;

    // Reset state
    step(); step();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_fields", 32'({wb_rd, wb_exception, wb_timeout}), 32'd0);
    chk("rst_operand_a", data_operandA, 32'd0);
    rst = 1'b0;
    step();

    // flush in IDLE swallows a same-cycle request
    flush = 1'b1;
    issue(1'b0, 32'd5, 32'd5, 5'd1);
    flush = 1'b0;
    step();
    chk("idle_flush_ready", 32'(req_ready), 32'd1);
    chk("idle_flush_no_pulse", 32'(n_mult + n_div), 32'd0);
    chk("idle_flush_no_latch", data_operandA, 32'd0);

    // 7 * 6 -> r5, RDY 33 cycles after the ctrl pulse (op cycle 34, cnt 32)
    rdy_on = 34; rdy_off = -1; m_res = 32'd42; m_exc = 1'b0;
    push(35, 5'd5, 32'd42, 1'b0, 1'b0);
    issue(1'b0, 32'd7, 32'd6, 5'd5);
    chk("mul_pulse_c1", 32'(ctrl_MULT), 32'd1);
    chk("mul_ready_c1", 32'(req_ready), 32'd0);
    chk("mul_operands", {data_operandA[15:0], data_operandB[15:0]}, {16'd7, 16'd6});
    repeat (35) step();
    chk("mul_pulses", 32'(n_mult), 32'd1);
    chk("mul_no_div", 32'(n_div), 32'd0);
    chk("mul_stall_cycles", 32'(n_stall), 32'd35);
    chk("mul_ready_after", 32'(req_ready), 32'd1);
    chk("mul_wb_hold", wb_data, 32'd42);

    // Stale RDY still high from the multiply; drop at cnt 2, re-raise at cnt 10
    rdy_on = 12; rdy_off = 4; m_res = 32'd81; m_exc = 1'b0;
    push(13, 5'd6, 32'd81, 1'b0, 1'b0);
    issue(1'b0, 32'd9, 32'd9, 5'd6);
    repeat (13) step();
    chk("stale_sb_empty", 32'(sb.size()), 32'd0);
    data_resultRDY = 1'b0;

    // 100 / 0 -> r7, exception arrives with RDY
    rdy_on = 8; rdy_off = 10; m_res = 32'hFFFF_FFFF; m_exc = 1'b1;
    push(9, 5'd7, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(1'b1, 32'd100, 32'd0, 5'd7);
    chk("div_pulse_c1", 32'(ctrl_DIV), 32'd1);
    chk("div_operands", {data_operandA[15:0], data_operandB[15:0]}, {16'd100, 16'd0});
    repeat (9) step();
    chk("div_pulses", 32'(n_div), 32'd1);
    chk("div_no_mult", 32'(n_mult), 32'd0);
    data_exception = 1'b0;

    // No RDY: 40 WAIT cycles (cnt 0..39 in op cycles 2..41), writeback in op cycle 42
    rdy_on = -1; rdy_off = -1;
    data_result = 32'hDEAD_BEEF;
    push(42, 5'd9, 32'd0, 1'b1, 1'b1);
    issue(1'b0, 32'd3, 32'd4, 5'd9);
    repeat (42) step();
    chk("to_sb_empty", 32'(sb.size()), 32'd0);

    // Qualified RDY exactly at cnt = MAX_CYC-1 beats the timeout
    rdy_on = 41; rdy_off = 42; m_res = 32'h1234_5678; m_exc = 1'b0;
    push(42, 5'd10, 32'h1234_5678, 1'b0, 1'b0);
    issue(1'b1, 32'd8, 32'd2, 5'd10);
    repeat (42) step();
    chk("edge_sb_empty", 32'(sb.size()), 32'd0);

    // flush 5 cycles into WAIT, with RDY arriving in the same cycle
    rdy_on = 7; rdy_off = 8; m_res = 32'd2; m_exc = 1'b0;
    issue(1'b0, 32'd1, 32'd2, 5'd3);
    repeat (6) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_ready_next", 32'(req_ready), 32'd1);
    chk("flush_no_wb", 32'(wb_valid), 32'd0);
    repeat (3) step();
    rdy_on = 5; rdy_off = 6; m_res = 32'd9; m_exc = 1'b0;
    push(6, 5'd4, 32'd9, 1'b0, 1'b0);
    issue(1'b0, 32'd3, 32'd3, 5'd4);
    repeat (6) step();
    chk("flush_next_sb_empty", 32'(sb.size()), 32'd0);

    // Asynchronous reset mid-WAIT, away from any clock edge
    rdy_on = -1; rdy_off = -1;
    issue(1'b1, 32'd50, 32'd5, 5'd11);
    repeat (4) step();
    chk("pre_rst_stall", 32'(stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_ctrl_wb", 32'({ctrl_MULT, ctrl_DIV, wb_valid}), 32'd0);
    chk("arst_operand_a", data_operandA, 32'd0);
    chk("arst_wb_data", wb_data, 32'd0);
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("never_both_ctrl", 32'(n_both), 32'd0);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/multdiv_issue.md
Name: multdiv_issue

Overview:
Initiator-side controller that drives the multiplier/divider ctrl protocol from the processor pipeline. It accepts one MULT or DIV request and latches the operands and destination register. It then issues a single-cycle ctrl_MULT or ctrl_DIV pulse and holds the operands stable. It waits for data_resultRDY, captures the result and exception, and delivers a one-cycle writeback. The pipeline is stalled for the whole operation.

Parameters:
MAX_CYC, 40, cycles waited in WAIT before declaring a timeout
IGNORE_CYC, 2, cycles after the ctrl pulse during which data_resultRDY is ignored (stale RDY from the previous op)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  pipeline requests an operation
req_op  in  1  0 = multiply, 1 = divide
req_a  in  32  operand A from pipeline
req_b  in  32  operand B from pipeline
req_rd  in  5  destination register
flush  in  1  abort current operation, no writeback
req_ready  out  1  high only in IDLE; request accepted on req_valid & req_ready
stall  out  1  ~req_ready
ctrl_MULT  out  1  one-cycle start pulse to the multiplier
ctrl_DIV  out  1  one-cycle start pulse to the divider
data_operandA  out  32  latched operand A
data_operandB  out  32  latched operand B
data_result  in  32  result from the unit
data_exception  in  1  overflow / divide-by-zero from the unit
data_resultRDY  in  1  unit result ready (level; may stay high after completion)
wb_valid  out  1  one-cycle writeback strobe
wb_rd  out  5  destination for writeback
wb_data  out  32  captured result
wb_exception  out  1  captured data_exception OR timeout
wb_timeout  out  1  set when the op ended by timeout

Behaviour:
- Reset is asynchronous and active-high; the clock is the single clk.
- On rst, state = IDLE and every output = 0, except req_ready = 1 and stall = 0. Internal counters = 0. The latched op, operands and rd = 0.
- States are IDLE, ISSUE, WAIT and DONE.
- IDLE:
  - On req_valid, latch req_op, req_a, req_b and req_rd, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly one cycle):
  - ctrl_MULT = ~op, or ctrl_DIV = op; never both.
  - Load the cycle counter with 0, then go to WAIT.
- WAIT:
  - The counter increments each cycle and saturates at MAX_CYC.
  - RDY is qualified: data_resultRDY & (cnt >= IGNORE_CYC).
  - Qualified RDY: capture data_result into wb_data and data_exception into wb_exception, clear wb_timeout, go to DONE.
  - Else, cnt == MAX_CYC-1: wb_data = 0, wb_exception = 1, wb_timeout = 1, go to DONE.
- DONE (one cycle):
  - wb_valid = 1 and wb_rd = latched rd, then go to IDLE.
  - A new request is not accepted in DONE.
- Output hold rules:
  - data_operandA/B are driven from the latch at all times and are stable from ISSUE through DONE.
  - wb_data, wb_exception and wb_timeout hold their values until the next capture. Only wb_valid marks them valid.
- Latency, with acceptance edge = cycle 0:
  - ctrl pulse high in cycle 1.
  - Earliest wb_valid in cycle 2 + IGNORE_CYC + 1 after the qualified RDY sample.
  - In general, wb_valid follows the qualifying RDY edge by one cycle.
- flush:
  - In ISSUE or WAIT, go to IDLE on the next edge with no wb_valid. A ctrl pulse already issued is not retracted.
  - flush in DONE still completes the writeback. The pipeline squashes it by rd ownership.
  - flush in IDLE has no effect, and a req_valid in the same cycle is not accepted.
- Simultaneous qualified RDY and counter at MAX_CYC-1: RDY wins, no timeout.
- rst mid-operation returns to IDLE immediately with no writeback. The unit is restarted only by the next ctrl pulse.
- No arithmetic is performed on the data path; the block only captures and passes it through.

Decomposition:
- Shared multdiv package:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3)
  - OP_MULT=1'b0 and OP_DIV=1'b1
  - default MAX_CYC and IGNORE_CYC
- One natural sub-module, multdiv_wait_ctr: a saturating cycle counter with load and qualify outputs, replacing a bare counter instance.
- The operand and result latches use the existing reg32 and mydffe cells.

Test Plan:
- Multiply 7 by 6 (req_op=0, rd=5); unit model raises RDY 33 cycles after ctrl_MULT.
  - ctrl_MULT is high for exactly one cycle and ctrl_DIV stays 0.
  - Exactly one wb_valid cycle: wb_rd=5, wb_data=42, wb_exception=0.
  - stall is high from cycle 1 through the wb cycle.
- Stale RDY: hold data_resultRDY=1 from the previous op into the new issue, drop it, then re-raise it at cnt=10.
  - The capture happens at cnt=10, not in the first IGNORE_CYC cycles.
- Divide 100 by 0 (req_op=1); the unit raises data_exception=1 together with RDY.
  - Only ctrl_DIV pulses.
  - wb_exception=1 and wb_timeout=0.
- The unit never raises RDY.
  - Exactly MAX_CYC=40 cycles after ISSUE, wb_valid=1 with wb_timeout=1, wb_exception=1 and wb_data=0.
- flush 5 cycles into WAIT.
  - No wb_valid.
  - req_ready=1 on the next cycle.
  - A new request 3*3 completes with wb_data=9.
- Assert rst asynchronously mid-WAIT.
  - All outputs clear immediately without waiting for a clock edge: req_ready=1, ctrl=0, wb_valid=0.
